// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle shifter (SLL/SRL/SRA/ROR) for the EX stage.
// Moves the operand by at most STEP bit positions per clock. It uses a
// start/busy/done handshake, and the stall logic holds the pipeline while busy=1.
//
// Handshake: a request is accepted on a rising edge where start=1 and the unit
// is not busy (state IDLE or DONE). On that edge data_in, mode and shamt are
// sampled. busy stays high for every SHIFT cycle. done is high for exactly one
// cycle when result is final. result holds that value until the next accept.
// A start that arrives while busy=1 is dropped, not queued.
module iter_shift_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    localparam logic [SHW-1:0] STEP_AMT = SHW'(STEP);

    state_t           state;
    state_t           state_next;
    logic [1:0]       mode_q;
    logic [SHW-1:0]   rem;
    logic [SHW-1:0]   step_k;
    logic [WIDTH-1:0] shifted;
    logic [2*WIDTH-1:0] rot;
    logic             accept;

    // A new op may start whenever no shift is in flight. This includes the DONE cycle.
    assign accept = start && (state != SHIFT);

    // Advance by STEP each cycle, or by the smaller remainder on the last cycle.
    assign step_k = (rem < STEP_AMT) ? rem : STEP_AMT;

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // One shift step of the working value. SRA refills from the current MSB.
    // The MSB still holds the original sign, so repeated steps preserve it.
    always_comb begin
        rot     = '0;
        shifted = result;
        case (mode_q)
            MODE_SLL: shifted = result << step_k;
            MODE_SRL: shifted = result >> step_k;
            MODE_SRA: shifted = $signed(result) >>> step_k;
            MODE_ROR: begin
                rot     = {result, result} >> step_k;
                shifted = rot[WIDTH-1:0];
            end
            default:  shifted = result;
        endcase
    end

    // Next-state logic. DONE lasts one cycle unless a new op is accepted in it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = (shamt == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (rem == step_k) state_next = DONE;
            end
            DONE: begin
                if (accept) state_next = (shamt == '0) ? DONE : SHIFT;
                else        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register. Reset takes priority over any pending start.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Datapath. It loads the operand on accept and then steps it during SHIFT.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            rem    <= '0;
            mode_q <= MODE_SLL;
        end else if (accept) begin
            result <= data_in;
            rem    <= shamt;
            mode_q <= mode;
        end else if (state == SHIFT) begin
            result <= shifted;
            rem    <= rem - step_k;
        end
    end

endmodule
